// File: rtl/pcm_capture_sched.sv
// pcm_capture_sched: PCM microphone capture sequencer.
// Divides the system clock down to the audio sample strobe, captures one mic
// sample per strobe, packs NS samples into one FIFO word, presents the word
// to the capture FIFO under backpressure, and counts words dropped because
// the previous word was still waiting for the FIFO.
module pcm_capture_sched #(
  parameter int FI = 50000000,
  parameter int FS = 15000,
  parameter int SW = 12,
  parameter int NS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [SW-1:0]    smp_in,
  output logic             smp_tick,
  output logic [SW*NS-1:0] fifo_wdata,
  output logic             fifo_wr,
  input  logic             fifo_full,
  output logic             busy,
  output logic             ovf,
  output logic [7:0]       ovf_cnt
);

  localparam int P  = FI / FS;
  localparam int CW = (P > 1) ? $clog2(P) : 1;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(P - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_idx;
  logic [SW*NS-1:0] r_part;
  logic [SW*NS-1:0] r_word;
  logic             r_pend;
  logic             r_tick;
  logic             r_busy;
  logic             r_ovf;
  logic [7:0]       r_ovf_cnt;

  logic             w_accept;
  logic             w_blocked;
  logic [SW*NS-1:0] w_done_word;

  // A pending word leaves on any edge where the FIFO has room; a pending word
  // that cannot leave on this edge blocks the next completed word.
  assign w_accept  = r_pend & ~fifo_full;
  assign w_blocked = r_pend & fifo_full;

  // Completed word = slots already packed plus the sample arriving now in the last slot.
  always_comb begin
    w_done_word = r_part;
    w_done_word[SW*(NS-1) +: SW] = smp_in;
  end

  // Capture FSM: sample-rate divider, slot packing, pending word and overflow tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_part    <= '0;
      r_word    <= '0;
      r_pend    <= 1'b0;
      r_tick    <= 1'b0;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else begin
      r_tick <= 1'b0;
      if (w_accept) begin
        r_pend <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          // start together with stop is treated as no request
          if (start && !stop) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= CNT_RELOAD;
            r_idx   <= '0;
            r_part  <= '0;
          end
        end
        S_RUN: begin
          if (stop) begin
            // Partial word is abandoned; only a word the FIFO has not yet
            // taken keeps the block busy.
            r_cnt <= '0;
            r_idx <= '0;
            if (w_blocked) begin
              r_state <= S_DRAIN;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            if (r_cnt == '0) begin
              r_tick <= 1'b1;
              r_cnt  <= CNT_RELOAD;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
            // The strobe cycle is ending: take the sample presented with it.
            if (r_tick) begin
              if (r_idx == IDX_LAST) begin
                r_idx <= '0;
                if (w_blocked) begin
                  r_ovf <= 1'b1;
                  if (r_ovf_cnt != 8'hFF) begin
                    r_ovf_cnt <= r_ovf_cnt + 8'd1;
                  end
                end else begin
                  r_word <= w_done_word;
                  r_pend <= 1'b1;
                end
              end else begin
                for (int k = 0; k < NS; k++) begin
                  if (r_idx == IW'(k)) begin
                    r_part[k*SW +: SW] <= smp_in;
                  end
                end
                r_idx <= r_idx + 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (!r_pend || w_accept) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign smp_tick   = r_tick;
  assign fifo_wdata = r_word;
  assign fifo_wr    = w_accept;
  assign busy       = r_busy;
  assign ovf        = r_ovf;
  assign ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_pcm_capture_sched.sv
// tb_pcm_capture_sched: self-checking bench for pcm_capture_sched.
// Directed tables and hand sequences with P=10, SW=12, NS=10, followed by a
// randomized run checked against a sample-queue reference model.
`timescale 1ns/1ps
module tb_pcm_capture_sched;

  localparam int P  = 10;
  localparam int SW = 12;
  localparam int NS = 10;
  localparam int WW = SW * NS;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [SW-1:0] smp_in = '0;
  logic          smp_tick;
  logic [WW-1:0] fifo_wdata;
  logic          fifo_wr;
  logic          fifo_full = 1'b0;
  logic          busy;
  logic          ovf;
  logic [7:0]    ovf_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pcm_capture_sched #(
    .FI(100), .FS(10), .SW(SW), .NS(NS)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .smp_in(smp_in), .smp_tick(smp_tick), .fifo_wdata(fifo_wdata),
    .fifo_wr(fifo_wr), .fifo_full(fifo_full), .busy(busy),
    .ovf(ovf), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Word whose slot k holds base+k.
  function automatic logic [WW-1:0] word_of(input int base);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < NS; k++) w[k*SW +: SW] = SW'(base + k);
    return w;
  endfunction

  // Sample presented in cycle rel after start: tick number during a tick cycle, junk otherwise.
  function automatic logic [SW-1:0] tick_smp(input int rel);
    if (rel > 0 && rel % P == 0) return SW'(rel / P);
    return 12'hABC;
  endfunction

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; fifo_full = 1'b0; smp_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- reference model (sample queue, edge arithmetic) ----------------
  typedef enum {M_IDLE, M_RUN, M_DRAIN} mmode_t;
  mmode_t        m_mode;
  int            m_edge;
  int            m_t0;
  logic [SW-1:0] m_q[$];
  logic          m_pend;
  logic [WW-1:0] m_word;
  int            m_ovfc;

  task automatic model_edge(input logic st, input logic sp, input logic full, input logic [SW-1:0] s);
    if (m_pend && !full) m_pend = 1'b0;
    case (m_mode)
      M_IDLE: if (st && !sp) begin
        m_mode = M_RUN; m_t0 = m_edge; m_q.delete();
      end
      M_RUN: begin
        if (sp) begin
          m_mode = m_pend ? M_DRAIN : M_IDLE;
        end else if ((m_edge - m_t0) > P && ((m_edge - m_t0 - 1) % P) == 0) begin
          m_q.push_back(s);
          if (m_q.size() == NS) begin
            if (m_pend) begin
              if (m_ovfc < 255) m_ovfc++;
            end else begin
              m_pend = 1'b1;
              for (int k = 0; k < NS; k++) m_word[k*SW +: SW] = m_q[k];
            end
            m_q.delete();
          end
        end
      end
      default: if (!m_pend) m_mode = M_IDLE;
    endcase
  endtask

  typedef struct {
    logic st;
    logic sp;
    logic exp_busy;
    logic exp_tick10;
  } idle_vec_t;

  typedef struct {
    int fs;      // fifo_full high in cycles [fs, fe)
    int fe;
    int wr1;     // cycle of first write
    int wr2;     // cycle of second write
    int nwr;     // write cycles seen up to cycle 320
    int w2base;  // first tick number in second written word
    int ovfc;    // expected dropped-word count
  } bp_vec_t;

  idle_vec_t iv[4];
  bp_vec_t   bp[6];

  initial begin
    iv[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    iv[1] = '{1'b1, 1'b1, 1'b0, 1'b0};
    iv[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    iv[3] = '{1'b1, 1'b0, 1'b1, 1'b1};

    bp[0] = '{0,   0,   101, 201, 3, 11, 0};
    bp[1] = '{95,  130, 130, 201, 3, 11, 0};
    bp[2] = '{100, 102, 102, 201, 3, 11, 0};
    bp[3] = '{0,   290, 290, 301, 2, 21, 1};
    bp[4] = '{150, 250, 101, 250, 3, 11, 0};
    bp[5] = '{201, 202, 101, 202, 3, 11, 0};

    // Reset state, asserted asynchronously before any clock edge
    #2 reset = 1'b1;
    #1;
    chkb("rst0 smp_tick", smp_tick, 1'b0);
    chkb("rst0 fifo_wr", fifo_wr, 1'b0);
    chkb("rst0 busy", busy, 1'b0);
    chkb("rst0 ovf", ovf, 1'b0);
    chki("rst0 ovf_cnt", int'(ovf_cnt), 0);
    chkw("rst0 fifo_wdata", fifo_wdata, '0);

    // IDLE start/stop decoding
    for (int i = 0; i < 4; i++) begin
      do_reset();
      start = iv[i].st; stop = iv[i].sp;
      for (int rel = 0; rel <= 12; rel++) begin
        @(posedge clk); #3;
        chkb($sformatf("idle%0d busy@%0d", i, rel), busy, iv[i].exp_busy);
        chkb($sformatf("idle%0d tick@%0d", i, rel), smp_tick, (rel == 10) ? iv[i].exp_tick10 : 1'b0);
      end
      start = 1'b0; stop = 1'b0;
    end

    // Basic capture and backpressure table
    for (int i = 0; i < 6; i++) begin
      int nwr, wr1, wr2;
      logic [WW-1:0] d1, d2;
      nwr = 0; wr1 = -1; wr2 = -1; d1 = '0; d2 = '0;
      do_reset();
      start = 1'b1;
      for (int rel = 0; rel <= 320; rel++) begin
        @(posedge clk); #1;
        start = 1'b0;
        fifo_full = (rel >= bp[i].fs && rel < bp[i].fe);
        smp_in = tick_smp(rel);
        #2;
        chkb($sformatf("bp%0d tick@%0d", i, rel), smp_tick, (rel > 0 && rel % P == 0));
        if (fifo_wr) begin
          nwr++;
          if (nwr == 1) begin wr1 = rel; d1 = fifo_wdata; end
          if (nwr == 2) begin wr2 = rel; d2 = fifo_wdata; end
        end
      end
      chki($sformatf("bp%0d wr1 cycle", i), wr1, bp[i].wr1);
      chki($sformatf("bp%0d wr2 cycle", i), wr2, bp[i].wr2);
      chki($sformatf("bp%0d write count", i), nwr, bp[i].nwr);
      chkw($sformatf("bp%0d wr1 data", i), d1, word_of(1));
      chkw($sformatf("bp%0d wr2 data", i), d2, word_of(bp[i].w2base));
      chki($sformatf("bp%0d ovf_cnt", i), int'(ovf_cnt), bp[i].ovfc);
      chkb($sformatf("bp%0d ovf", i), ovf, (bp[i].ovfc != 0));
    end
    fifo_full = 1'b0;

    // Asynchronous reset mid-RUN with a word pending and an overflow recorded
    do_reset();
    start = 1'b1; fifo_full = 1'b1;
    for (int rel = 0; rel <= 205; rel++) begin
      @(posedge clk); #1;
      start = 1'b0;
      smp_in = tick_smp(rel);
    end
    #1;
    chkw("rstmid pre wdata", fifo_wdata, word_of(1));
    chkb("rstmid pre ovf", ovf, 1'b1);
    chkb("rstmid pre busy", busy, 1'b1);
    reset = 1'b1; fifo_full = 1'b0;
    #1;
    chkb("rstmid smp_tick", smp_tick, 1'b0);
    chkb("rstmid fifo_wr", fifo_wr, 1'b0);
    chkb("rstmid busy", busy, 1'b0);
    chkb("rstmid ovf", ovf, 1'b0);
    chki("rstmid ovf_cnt", int'(ovf_cnt), 0);
    chkw("rstmid fifo_wdata", fifo_wdata, '0);
    @(posedge clk); #1 reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #3;
      chkb($sformatf("rstpost wr@%0d", c), fifo_wr, 1'b0);
      chkb($sformatf("rstpost busy@%0d", c), busy, 1'b0);
    end

    // Stop mid-word (on the edge of tick 5), then restart: slot index must restart
    do_reset();
    start = 1'b1;
    for (int rel = 0; rel <= 170; rel++) begin
      int ph;
      logic on;
      @(posedge clk); #1;
      start = (rel == 60);
      stop  = (rel == 49);
      ph = (rel >= 61) ? rel - 61 : rel;
      on = (rel < 50) || (rel >= 61);
      smp_in = tick_smp(ph);
      #2;
      chkb($sformatf("stop tick@%0d", rel), smp_tick, on && ph > 0 && ph % P == 0);
      chkb($sformatf("stop busy@%0d", rel), busy, on);
      chkb($sformatf("stop wr@%0d", rel), fifo_wr, (rel == 162));
      if (rel == 162) chkw("stop restart data", fifo_wdata, word_of(1));
    end
    start = 1'b0; stop = 1'b0;

    // Stop with a word pending and FIFO full: DRAIN until the write is taken
    do_reset();
    start = 1'b1;
    for (int rel = 0; rel <= 185; rel++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stop = (rel == 150);
      fifo_full = (rel < 170);
      smp_in = tick_smp(rel);
      #2;
      chkb($sformatf("drain tick@%0d", rel), smp_tick, rel > 0 && rel % P == 0 && rel <= 150);
      chkb($sformatf("drain busy@%0d", rel), busy, rel < 171);
      chkb($sformatf("drain wr@%0d", rel), fifo_wr, rel == 170);
      if (rel == 170) chkw("drain data", fifo_wdata, word_of(1));
    end
    stop = 1'b0; fifo_full = 1'b0;

    // start pulsed during RUN leaves the tick phase alone
    do_reset();
    start = 1'b1;
    for (int rel = 0; rel <= 60; rel++) begin
      @(posedge clk); #1;
      start = (rel >= 33 && rel <= 35);
      #2;
      chkb($sformatf("restart tick@%0d", rel), smp_tick, rel > 0 && rel % P == 0);
    end
    start = 1'b0;

    // Sustained full: dropped-word counter saturates at 255
    do_reset();
    start = 1'b1; fifo_full = 1'b1; smp_in = 12'h5A5;
    for (int rel = 0; rel <= 25800; rel++) begin
      @(posedge clk);
      if (rel == 0) #1 start = 1'b0;
      if (rel == 1000) begin #3; chki("sat ovf_cnt@1000", int'(ovf_cnt), 8); end
      if (rel == 25550) begin #3; chki("sat ovf_cnt@25550", int'(ovf_cnt), 254); end
    end
    #3;
    chki("sat ovf_cnt final", int'(ovf_cnt), 255);
    chkb("sat ovf", ovf, 1'b1);
    chkb("sat fifo_wr", fifo_wr, 1'b0);
    chkw("sat wdata held", fifo_wdata, {NS{12'h5A5}});
    fifo_full = 1'b0;

    // Randomized run against the reference model
    do_reset();
    m_mode = M_IDLE; m_edge = 0; m_t0 = 0; m_pend = 1'b0; m_word = '0; m_ovfc = 0;
    m_q.delete();
    begin
      int full_left;
      full_left = 0;
      for (int c = 0; c < 6000; c++) begin
        @(posedge clk);
        m_edge++;
        model_edge(start, stop, fifo_full, smp_in);
        #1;
        smp_in = SW'($urandom_range(0, 4095));
        if (full_left == 0) begin
          fifo_full = ($urandom_range(0, 2) == 0);
          full_left = fifo_full ? $urandom_range(1, 250) : $urandom_range(1, 80);
        end
        full_left--;
        if (m_mode == M_IDLE) begin
          start = ($urandom_range(0, 3) == 0);
          stop  = ($urandom_range(0, 4) == 0);
        end else begin
          start = ($urandom_range(0, 15) == 0);
          stop  = ($urandom_range(0, 299) == 0);
        end
        #2;
        chkb($sformatf("rnd tick@%0d", c), smp_tick,
             m_mode == M_RUN && m_edge > m_t0 && ((m_edge - m_t0) % P) == 0);
        chkb($sformatf("rnd busy@%0d", c), busy, m_mode != M_IDLE);
        chkb($sformatf("rnd wr@%0d", c), fifo_wr, m_pend && !fifo_full);
        chkb($sformatf("rnd ovf@%0d", c), ovf, m_ovfc > 0);
        chki($sformatf("rnd ovf_cnt@%0d", c), int'(ovf_cnt), m_ovfc);
        if (m_pend) chkw($sformatf("rnd wdata@%0d", c), fifo_wdata, m_word);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcm_capture_sched.md
# pcm_capture_sched

Sequencer for the PCM microphone capture path. It generates the audio sample strobe from the system clock, captures one mic sample per strobe, and packs NS samples into one FIFO word (120 bits by default). It sits between the mic sample source and the 120-bit capture FIFO, handles FIFO backpressure, and counts dropped words.

## Interface
Parameters:
- FI, 50000000, system clock frequency seen by the block (Hz).
- FS, 15000, sample rate (Hz). Sample period P = FI/FS cycles, integer division, P ≥ 2.
- SW, 12, sample width (bits).
- NS, 10, samples per FIFO word.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  level; sampled in IDLE, begins capture.
- stop  in  1  level; sampled in RUN, ends capture.
- smp_in  in  SW  mic sample; captured on the edge that ends the smp_tick cycle.
- smp_tick  out  1  one-cycle sample strobe, every P cycles while in RUN.
- fifo_wdata  out  SW*NS  packed word; sample 0 in bits [SW-1:0], sample k in [SW*(k+1)-1:SW*k].
- fifo_wr  out  1  write strobe = pend & ~fifo_full (combinational from fifo_full).
- fifo_full  in  1  FIFO cannot accept a write this cycle.
- busy  out  1  high in RUN or DRAIN.
- ovf  out  1  sticky; set when a completed word is dropped.
- ovf_cnt  out  8  dropped-word count, saturates at 255.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: no ticks. start=1 and stop=0 → RUN, load cnt=P-1, clear slot index and partial word. start and stop both high → stay in IDLE.
- RUN: cnt decrements every cycle. When cnt==0: smp_tick=1 for that cycle, cnt reloads P-1. At the end of the tick cycle: smp_in is written to slot idx, idx increments.
- Word completion: when idx reaches NS-1 and a capture happens, the full word (including this sample) moves to the output register fifo_wdata, pend is set, idx→0.
- Pending write: fifo_wr is high while pend=1 and fifo_full=0. pend clears at the edge where fifo_wr=1. fifo_wdata holds steady while pend=1.
- Overflow: if a word completes while pend=1, the new word is discarded, pend and fifo_wdata keep the old word, ovf←1, and ovf_cnt increments (saturating). Capture continues.
- RUN with stop=1 → DRAIN if pend=1, otherwise → IDLE. The partial word is discarded and no tick is issued in the stop cycle. start is ignored in RUN.
- DRAIN: no ticks. Leave for IDLE at the edge where the pending write is accepted. start is ignored.
- ovf and ovf_cnt clear only on reset.
- Reset (asynchronous, any state, mid-word or mid-write): state=IDLE, cnt=0, idx=0, pend=0, fifo_wdata=0, smp_tick=0, fifo_wr=0, busy=0, ovf=0, ovf_cnt=0.

## Timing
- start sampled high at edge E0 → busy high after E0. smp_tick is high in the cycles beginning at edges E0+P, E0+2P, and so on.
- The sample for tick n (n=1..) is captured at edge E0+nP+1.
- A word completes at edge E0+NS·P+1. fifo_wr is high in the cycle beginning at that edge if fifo_full=0, so latency is 0 cycles from completion to write.
- Backpressure delays the write but never changes sample timing. A word is lost only if the FIFO stays full for a full NS·P cycles.
- stop sampled at edge Es → state changes at Es. A tick scheduled in the cycle starting at Es is not issued, and no capture happens after Es.
- smp_tick and busy are registered. fifo_wr is combinational on fifo_full.

## Test plan
Bench parameters: FI=100, FS=10 (P=10), SW=12, NS=10.
- Reset: assert reset asynchronously mid-RUN with a word pending → all outputs 0 immediately, no fifo_wr after release.
- Basic capture: start at edge 0, smp_in = tick number (1..10), fifo_full=0 → ticks at edges 10,20,…,100. fifo_wr high for exactly 1 cycle from edge 101, fifo_wdata = {12'd10,…,12'd1}. Second word written from edge 201.
- Backpressure: fifo_full=1 over edges 95–130 → fifo_wr low throughout. Write occurs in the first cycle with fifo_full=0. Data unchanged, ovf=0, tick spacing stays at 10.
- Overflow: fifo_full held at 1 for 300 cycles → first word pending, second word dropped, ovf=1, ovf_cnt=1. On release the first word is written. ovf_cnt saturates at 255 under sustained full.
- Stop: stop mid-word (after tick 4) → IDLE, no fifo_wr, busy low. Stop with a word pending and fifo_full=1 → DRAIN, busy stays high, then IDLE after the write.
- Simultaneous start and stop in IDLE → stays IDLE, no ticks. start pulsed during RUN → tick phase unchanged.
